serial_to_parallel: RTL
=======================

# serial_to_parallel

Serial-frame receiver that turns a one-bit serial stream back into a parallel word. It is the receive-side counterpart of the team's parallel-to-serial transmitter. It detects a start bit, shifts in WIDTH data bits, checks a stop bit, then presents the word with a one-cycle valid strobe. It sits on the same clock as the transmitter, with no oversampling: one bit per clock.

## Interface
Parameters:
- WIDTH, 8, number of data bits per frame (2..32)
- MSB_FIRST, 1, 1 = first data bit after start is bit WIDTH-1; 0 = first is bit 0

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ser_in  input  1  serial line; idles low
- data_out  output  WIDTH  last correctly framed word; holds between frames
- data_valid  output  1  one-cycle strobe, data_out updated this cycle
- frame_err  output  1  one-cycle strobe, stop bit was wrong
- busy  output  1  high while a frame is in progress (DATA or STOP state)

## Operation
- Frame format on ser_in, one bit per clock: start = 1, then WIDTH data bits, then stop = 0. The idle line is 0.
- FSM states:
  - IDLE: wait for ser_in = 1. When seen, go to DATA, clear the bit counter and the shift register.
  - DATA: sample ser_in every cycle into the shift register and increment the counter. After WIDTH samples (counter = WIDTH-1 sampled), go to STOP.
  - STOP: sample ser_in.
    - If 0: load data_out from the shift register, pulse data_valid, go to IDLE.
    - If 1: pulse frame_err, leave data_out unchanged, go to IDLE. The 1 is not reinterpreted as a new start bit.
- Shift direction:
  - MSB_FIRST = 1: shift left, new bit into LSB.
  - MSB_FIRST = 0: shift right, new bit into MSB.
- The counter is $clog2(WIDTH)+1 bits wide and never wraps within a frame.
- A 1 on ser_in during DATA is data, never a start bit. There is no resynchronisation mid-frame.
- data_valid and frame_err are never high in the same cycle.

## Timing
- Reset values: data_out = 0, data_valid = 0, frame_err = 0, busy = 0, state = IDLE, counter = 0, shift register = 0.
- A reset asserted mid-frame aborts the frame with no strobe. The next cycle after reset is IDLE.
- Cycle numbering: let the start bit be sampled at edge T0.
  - Data bits are sampled at T1..T(WIDTH).
  - The stop bit is sampled at T(WIDTH+1).
  - data_valid / frame_err are high for the cycle following T(WIDTH+1), i.e. registered outputs.
- Latency from start bit to data_valid is WIDTH+2 cycles (10 for WIDTH = 8).
- busy is high from the cycle after T0 through the cycle after the stop sample is taken, minus that final cycle. Precisely, busy = (state != IDLE).
- Back-to-back frames: a start bit may arrive in the cycle immediately after the stop bit. The FSM is already in IDLE and accepts it. The frame period is therefore WIDTH+2 cycles, with no gap required.
- data_out changes only in the cycle data_valid is high.

## Structure
- Shared package serdes_pkg holds:
  - the state typedef (IDLE, DATA, STOP)
  - constants START_BIT = 1'b1, STOP_BIT = 1'b0, IDLE_LEVEL = 1'b0
- The transmitter uses the same package, so framing constants cannot diverge.
- One sub-module is natural: serdes_shift_reg (parameterised WIDTH/MSB_FIRST shift register with synchronous clear). It is reusable by the transmitter with a parallel-load port.
- The FSM, counter and output registers stay in the top module.

## Test plan
- Reset then frame 0xCA, MSB_FIRST = 1: drive 1, then 1,1,0,0,1,0,1,0, then 0. Required: data_out = 0xCA, data_valid high exactly 10 cycles after the start bit, for one cycle; busy high for 9 cycles.
- Back-to-back frames 0xCA then 0x56 with no idle gap. Required: two data_valid pulses 10 cycles apart, data_out = 0xCA then 0x56, frame_err never high.
- Frame 0x56 with stop bit = 1. Required: frame_err pulses once, data_valid stays low, data_out keeps its previous value (0xCA). The FSM is in IDLE the next cycle, and a start bit the cycle after that is accepted.
- rst asserted after 4 data bits of 0xFF, then frame 0x01. Required: no strobe for the aborted frame, all outputs 0 after reset, then data_out = 0x01 with data_valid.
- MSB_FIRST = 0, serial bits after start 0,1,0,1,0,0,1,1. Required: data_out = 0xCA.
- Idle line held at 0 for 50 cycles. Required: busy, data_valid and frame_err remain 0, and data_out holds 0.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared framing definitions for the serial transmitter/receiver pair.
// Holds the FSM state type and the line-level framing constants so that
// both directions always agree on start/stop/idle levels.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } serdes_state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  // Bit counter width: holds 0..WIDTH without wrapping inside a frame.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serdes_shift_reg.sv
// Parameterised shift register shared by the serial receiver and transmitter.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (clears contents)
//   clr        synchronous clear, same effect as rst
//   shift_en   shift one position, ser_in enters at the fill end
//   load_en    parallel load from load_data (takes priority over shift)
//   load_data  parallel word for load_en
//   ser_in     serial bit shifted in
//   data       current register contents
module serdes_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
    end else if (load_en) begin
      data <= load_data;
    end else if (shift_en) begin
      // MSB-first streams fill from the LSB so the first bit ends up on top.
      if (MSB_FIRST != 0) begin
        data <= {data[WIDTH-2:0], ser_in};
      end else begin
        data <= {ser_in, data[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-frame receiver: start bit (1), WIDTH data bits, stop bit (0),
// one bit per clock, no oversampling. Presents each well-framed word with
// a one-cycle data_valid strobe; a bad stop bit gives a frame_err strobe.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   ser_in      serial line, idles low
//   data_out    last correctly framed word, held between frames
//   data_valid  one-cycle strobe, data_out updated this cycle
//   frame_err   one-cycle strobe, stop bit was wrong
//   busy        high while in DATA or STOP
//
// state | meaning
// IDLE  | line idle, waiting for a start bit
// DATA  | shifting in WIDTH data bits
// STOP  | sampling the stop bit, then strobe and return to IDLE
module serial_to_parallel
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serdes_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q;
  logic             sh_clr, sh_en;
  logic             valid_d, err_d;

  serdes_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (sh_clr),
    .shift_en (sh_en),
    .load_en  (1'b0),
    .load_data({WIDTH{1'b0}}),
    .ser_in   (ser_in),
    .data     (shift_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ser_in == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      DATA: begin
        // Any level here is data; there is no mid-frame resync.
        sh_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // A bad stop bit is consumed here and never taken as a new start.
        state_d = IDLE;
        if (ser_in == STOP_BIT) begin
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_valid <= valid_d;
      frame_err  <= err_d;
      if (valid_d) begin
        data_out <= shift_q;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
